// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared FSM state encoding and layer-geometry helpers for the
//            slide_window_conv sequencer and datapath.
// Revision : 1.0
// ============================================================================
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_MAC   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic int unsigned out_dim(input int unsigned n, input int unsigned f,
                                            input int unsigned p, input int unsigned s);
        return (n + 2 * p - f) / s + 1;
    endfunction

    function automatic int unsigned out_count(input int unsigned rn, input int unsigned cn,
                                              input int unsigned rf, input int unsigned cf,
                                              input int unsigned p,  input int unsigned s);
        return out_dim(rn, rf, p, s) * out_dim(cn, cf, p, s);
    endfunction

    function automatic int unsigned tap_count(input int unsigned rf, input int unsigned cf);
        return rf * cf;
    endfunction

    // Index width for a counter over 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_seq_ctrl_if
// Brief    : Scheduler handshake plus datapath control bundle of the sequencer.
// Revision : 1.0
// ============================================================================
interface conv_seq_ctrl_if #(
    parameter int unsigned WIN_W = 5,
    parameter int unsigned TAP_W = 4
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             clk_en;
    logic             clr;
    logic             en_wr;
    logic             en_rd;
    logic             wr;
    logic             en_MAC;
    logic             en_MAC_out;
    logic [WIN_W-1:0] win_idx;
    logic [TAP_W-1:0] tap_idx;
    logic             y_valid;
    logic [31:0]      cycle_cnt;

    modport master (
        output start, abort,
        input  busy, done, clk_en, clr, en_wr, en_rd, wr, en_MAC, en_MAC_out,
        input  win_idx, tap_idx, y_valid, cycle_cnt
    );

    modport slave (
        input  start, abort,
        output busy, done, clk_en, clr, en_wr, en_rd, wr, en_MAC, en_MAC_out,
        output win_idx, tap_idx, y_valid, cycle_cnt
    );
endinterface
`default_nettype wire

// File: rtl/conv_win_tap_cnt.sv
`default_nettype none
// ============================================================================
// Module   : conv_win_tap_cnt
// Brief    : Nested filter-tap / output-window counter with last-value flags.
// Revision : 1.0
// ============================================================================
module conv_win_tap_cnt #(
    parameter int unsigned OUT_N = 25,
    parameter int unsigned TAPS  = 9,
    parameter int unsigned WIN_W = 5,
    parameter int unsigned TAP_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    output logic      [WIN_W-1:0] o_win_idx,
    output logic      [TAP_W-1:0] o_tap_idx,
    output logic                  o_tap_last,
    output logic                  o_win_last,
    output logic                  o_tap_pre_last
);
    localparam logic [WIN_W-1:0] c_win_max = WIN_W'(OUT_N - 1);
    localparam logic [TAP_W-1:0] c_tap_max = TAP_W'(TAPS - 1);

    logic [WIN_W-1:0] r_win;
    logic [TAP_W-1:0] r_tap;

    // Window index stops at its last value; only the tap index wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
            r_tap <= '0;
        end else if (i_clr) begin
            r_win <= '0;
            r_tap <= '0;
        end else if (i_en) begin
            if (r_tap == c_tap_max) begin
                r_tap <= '0;
                if (r_win != c_win_max) begin
                    r_win <= r_win + 1'b1;
                end
            end else begin
                r_tap <= r_tap + 1'b1;
            end
        end
    end

    assign o_win_idx  = r_win;
    assign o_tap_idx  = r_tap;
    assign o_tap_last = (r_tap == c_tap_max);
    assign o_win_last = (r_win == c_win_max);

    // Flags the cycle before the last tap so y_valid can be registered.
    if (TAPS == 1) begin : g_single_tap
        assign o_tap_pre_last = 1'b1;
    end else begin : g_multi_tap
        localparam logic [TAP_W-1:0] c_tap_pre = TAP_W'(TAPS - 2);
        assign o_tap_pre_last = (r_tap == c_tap_pre);
    end

endmodule
`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_seq_ctrl
// Brief    : Sequences one slide_window_conv layer pass (clear, write, read,
//            MAC sweep). Optional pass cycle counter: CONV_SEQ_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned R_N    = 5,
    parameter int unsigned C_N    = 5,
    parameter int unsigned R_F    = 3,
    parameter int unsigned C_F    = 3,
    parameter int unsigned P      = 1,
    parameter int unsigned S      = 1,
    parameter int unsigned WR_CYC = 9
) (
    input  wire logic       clk,
    input  wire logic       rst,
    conv_seq_ctrl_if.slave  bus
);
    localparam int unsigned c_out_n = out_count(R_N, C_N, R_F, C_F, P, S);
    localparam int unsigned c_taps  = tap_count(R_F, C_F);
    localparam int unsigned c_win_w = idx_width(c_out_n);
    localparam int unsigned c_tap_w = idx_width(c_taps);
    localparam int unsigned c_wr_w  = idx_width(WR_CYC);
    localparam logic [c_wr_w-1:0] c_wr_last = c_wr_w'(WR_CYC - 1);

    state_t             r_state;
    logic [c_wr_w-1:0]  r_wr_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_clr;
    logic               r_en_wr;
    logic               r_en_rd;
    logic               r_wr;
    logic               r_en_mac;
    logic               r_en_mac_out;
    logic               r_y_valid;

    logic [c_win_w-1:0] w_win_idx;
    logic [c_tap_w-1:0] w_tap_idx;
    logic               w_tap_last;
    logic               w_win_last;
    logic               w_tap_pre_last;
    logic               w_mac_last;
    logic               w_cnt_clr;
    logic               w_cnt_en;

    assign w_mac_last = w_tap_last && w_win_last;
    // Indices live only in MAC/DONE; they clear on the edge leaving DONE or on abort.
    assign w_cnt_clr  = bus.abort || (r_state != ST_MAC);
    assign w_cnt_en   = (r_state == ST_MAC) && !w_mac_last;

    conv_win_tap_cnt #(
        .OUT_N (c_out_n),
        .TAPS  (c_taps),
        .WIN_W (c_win_w),
        .TAP_W (c_tap_w)
    ) u_win_tap_cnt (
        .clk            (clk),
        .rst            (rst),
        .i_clr          (w_cnt_clr),
        .i_en           (w_cnt_en),
        .o_win_idx      (w_win_idx),
        .o_tap_idx      (w_tap_idx),
        .o_tap_last     (w_tap_last),
        .o_win_last     (w_win_last),
        .o_tap_pre_last (w_tap_pre_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wr_cnt     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_clr        <= 1'b0;
            r_en_wr      <= 1'b0;
            r_en_rd      <= 1'b0;
            r_wr         <= 1'b0;
            r_en_mac     <= 1'b0;
            r_en_mac_out <= 1'b0;
            r_y_valid    <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_clr        <= 1'b0;
            r_en_wr      <= 1'b0;
            r_en_rd      <= 1'b0;
            r_wr         <= 1'b0;
            r_en_mac     <= 1'b0;
            r_en_mac_out <= 1'b0;
            r_y_valid    <= 1'b0;
            if (bus.abort) begin
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_wr_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_state <= ST_CLEAR;
                            r_busy  <= 1'b1;
                            r_clr   <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        r_state  <= ST_WRITE;
                        r_wr_cnt <= '0;
                        r_en_wr  <= 1'b1;
                        r_wr     <= 1'b1;
                    end
                    ST_WRITE: begin
                        if (r_wr_cnt == c_wr_last) begin
                            r_state <= ST_READ;
                            r_en_rd <= 1'b1;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                            r_en_wr  <= 1'b1;
                            r_wr     <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        r_state      <= ST_MAC;
                        r_en_rd      <= 1'b1;
                        r_en_mac     <= 1'b1;
                        r_en_mac_out <= 1'b1;
                        r_y_valid    <= (c_taps == 1);
                    end
                    ST_MAC: begin
                        if (w_mac_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_en_rd      <= 1'b1;
                            r_en_mac     <= 1'b1;
                            r_en_mac_out <= 1'b1;
                            r_y_valid    <= w_tap_pre_last;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_cnt;
    logic [31:0] r_cycle_cnt;

    // r_perf_cnt holds the 1-based index of the current busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cnt  <= '0;
            r_cycle_cnt <= '0;
        end else if (!bus.abort) begin
            if (r_state == ST_IDLE && bus.start) begin
                r_perf_cnt <= 32'd1;
            end else if (r_busy) begin
                r_perf_cnt <= r_perf_cnt + 32'd1;
            end
            if (r_state == ST_MAC && w_mac_last) begin
                r_cycle_cnt <= r_perf_cnt + 32'd1;
            end
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
`else
    assign bus.cycle_cnt = '0;
`endif

    assign bus.busy       = r_busy;
    assign bus.clk_en     = r_busy;
    assign bus.done       = r_done;
    assign bus.clr        = r_clr;
    assign bus.en_wr      = r_en_wr;
    assign bus.en_rd      = r_en_rd;
    assign bus.wr         = r_wr;
    assign bus.en_MAC     = r_en_mac;
    assign bus.en_MAC_out = r_en_mac_out;
    assign bus.y_valid    = r_y_valid;
    assign bus.win_idx    = w_win_idx;
    assign bus.tap_idx    = w_tap_idx;

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_seq_ctrl
// Brief    : Scoreboard bench for conv_seq_ctrl at default geometry (5x5, 3x3, P=1, S=1).
// Revision : 1.0
// ============================================================================
module tb_conv_seq_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       clk_en;
        logic       clr;
        logic       en_wr;
        logic       en_rd;
        logic       wr;
        logic       en_mac;
        logic       en_mac_out;
        logic       y_valid;
        logic [4:0] win;
        logic [3:0] tap;
    } obs_t;

    typedef struct packed {
        logic [4:0] win;
        logic [3:0] tap;
    } yev_t;

`ifdef CONV_SEQ_PERF_CNT_EN
    localparam logic [31:0] EXP_CC = 32'd237;
`else
    localparam logic [31:0] EXP_CC = 32'd0;
`endif
    localparam int LAT = 237;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    obs_t exp_q[$];
    yev_t y_q[$];
    int   d_q[$];

    conv_seq_ctrl_if #(.WIN_W(5), .TAP_W(4)) bus();

    conv_seq_ctrl #(
        .R_N(5), .C_N(5), .R_F(3), .C_F(3), .P(1), .S(1), .WR_CYC(9)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cycle k of a pass, k=1 being the cycle right after the start edge.
    function automatic obs_t exp_at(input int k);
        obs_t o;
        o = '0;
        if (k >= 1 && k <= LAT) begin
            o.busy   = 1'b1;
            o.clk_en = 1'b1;
        end
        if (k == 1) begin
            o.clr = 1'b1;
        end else if (k >= 2 && k <= 10) begin
            o.en_wr = 1'b1;
            o.wr    = 1'b1;
        end else if (k == 11) begin
            o.en_rd = 1'b1;
        end else if (k >= 12 && k <= 236) begin
            o.en_rd      = 1'b1;
            o.en_mac     = 1'b1;
            o.en_mac_out = 1'b1;
            o.tap        = 4'((k - 12) % 9);
            o.win        = 5'((k - 12) / 9);
            o.y_valid    = (((k - 12) % 9) == 8);
        end else if (k == LAT) begin
            o.done = 1'b1;
            o.win  = 5'd24;
            o.tap  = 4'd8;
        end
        return o;
    endfunction

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back('0);
    endtask

    task automatic push_pass(input int base, input int kmax);
        yev_t ev;
        for (int k = 1; k <= kmax; k++) begin
            exp_q.push_back(exp_at(k));
            if (k >= 12 && k <= 236 && ((k - 12) % 9) == 8) begin
                ev.win = 5'((k - 12) / 9);
                ev.tap = 4'd8;
                y_q.push_back(ev);
            end
            if (k == LAT) d_q.push_back(base + LAT);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            g++;
            if (g > 2000) begin
                total++;
                bad++;
                $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_full_pass();
        bus.start = 1'b1;
        push_idle(1);
        push_pass(cyc, LAT);
        push_idle(3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_drain();
    endtask

    always @(negedge clk) begin
        obs_t got;
        obs_t want;
        yev_t ev;
        int   dc;
        got.busy       = bus.busy;
        got.done       = bus.done;
        got.clk_en     = bus.clk_en;
        got.clr        = bus.clr;
        got.en_wr      = bus.en_wr;
        got.en_rd      = bus.en_rd;
        got.wr         = bus.wr;
        got.en_mac     = bus.en_MAC;
        got.en_mac_out = bus.en_MAC_out;
        got.y_valid    = bus.y_valid;
        got.win        = bus.win_idx;
        got.tap        = bus.tap_idx;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL trace cyc=%0d got=%h want=%h", cyc, got, want);
            end
        end
        if (bus.y_valid === 1'b1) begin
            total++;
            if (y_q.size() == 0) begin
                bad++;
                $display("FAIL y_valid_unexpected cyc=%0d got win=%0d tap=%0d want none", cyc, bus.win_idx, bus.tap_idx);
            end else begin
                ev = y_q.pop_front();
                if ({bus.win_idx, bus.tap_idx} !== ev) begin
                    bad++;
                    $display("FAIL y_valid_idx cyc=%0d got win=%0d tap=%0d want win=%0d tap=%0d",
                             cyc, bus.win_idx, bus.tap_idx, ev.win, ev.tap);
                end
            end
        end
        if (bus.done === 1'b1) begin
            total++;
            if (d_q.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected got cyc=%0d want none", cyc);
            end else begin
                dc = d_q.pop_front();
                if (cyc != dc) begin
                    bad++;
                    $display("FAIL done_cycle got=%0d want=%0d", cyc, dc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cycle_cnt", bus.cycle_cnt, 32'd0);
        rst = 1'b0;

        // Quiet after reset with no start.
        push_idle(20);
        wait_drain();

        // Full pass at defaults.
        run_full_pass();
        check("cycle_cnt_pass1", bus.cycle_cnt, EXP_CC);

        // Abort during MAC cycle 50 (k=61).
        bus.start = 1'b1;
        push_idle(1);
        push_pass(cyc, 61);
        push_idle(4);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_en_mac", 32'(bus.en_MAC), 32'd0);
        wait_drain();
        check("abort_cycle_cnt", bus.cycle_cnt, EXP_CC);

        run_full_pass();
        check("cycle_cnt_after_abort", bus.cycle_cnt, EXP_CC);

        // start together with abort in IDLE: stays IDLE.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        push_idle(4);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        wait_drain();

        // start held through a whole pass: exactly one back-to-back second pass.
        bus.start = 1'b1;
        base = cyc;
        push_idle(1);
        push_pass(base, LAT);
        push_idle(1);
        push_pass(base + LAT + 1, LAT);
        push_idle(3);
        @(posedge clk);
        #1;
        repeat (LAT + 1) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_drain();

        // Asynchronous reset during WRITE cycle 4 (k=5).
        bus.start = 1'b1;
        push_idle(1);
        push_pass(cyc, 4);
        push_idle(6);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_en_wr", 32'(bus.en_wr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_drain();
        check("rst_mid_cycle_cnt", bus.cycle_cnt, 32'd0);

        run_full_pass();
        check("cycle_cnt_after_rst", bus.cycle_cnt, EXP_CC);

        check("y_events_left", 32'(y_q.size()), 32'd0);
        check("done_events_left", 32'(d_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
